// File: rtl/fft_out_collector.sv
// fft_out_collector
//   Collects one 32-point FFT result frame that arrives as a stream of
//   finish_i strobes. Gaps between strobes are allowed. Once the frame is
//   complete, it is drained through a valid/ready output port.
//   Data passes through bit-exact.
//
//   Optional build macro FFT_OUT_BITREV_EN: sample k is stored at the 5-bit
//   bit-reversal of k. A bit-reversed FFT output stream therefore drains in
//   natural frequency order. When the macro is undefined, sample k is stored
//   at address k and the frame drains in arrival order.
//
// Ports
//   clk, rst         single clock; synchronous active-high reset
//   finish_i         result strobe; X_r / X_i are valid while it is high
//   X_r, X_i         real / imaginary result words (DW bits, two's complement)
//   out_valid        a buffered result is presented (DRAIN state)
//   out_ready        downstream accepts the presented result
//   out_r, out_i     presented real / imaginary words
//   out_idx          buffer index of the presented result (0..31)
//   out_last         presented result is the final one of the frame
//   busy             high in CAPTURE or DRAIN
//   overflow         sticky; set when a strobe arrives during DRAIN
module fft_out_collector #(
  parameter int DW = 18,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          finish_i,
  input  logic [DW-1:0] X_r,
  input  logic [DW-1:0] X_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic [4:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  state_t      state, state_d;
  sample_t     buffer [N];
  logic [5:0]  wcnt;
  logic [4:0]  rcnt;
  logic [4:0]  wslot;
  logic [4:0]  waddr;
  logic        wr_en;
  logic        xfer;

  function automatic logic [4:0] addr_of(input logic [4:0] k);
`ifdef FFT_OUT_BITREV_EN
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[b] = k[4-b];
    return r;
`else
    return k;
`endif
  endfunction

  // The first sample of a frame always lands on slot 0. This holds even when
  // wcnt still reads 32 from the previous frame.
  assign wslot = (state == IDLE) ? 5'd0 : wcnt[4:0];
  assign waddr = addr_of(wslot);
  assign wr_en = finish_i && !rst && (state == IDLE || state == CAPTURE);
  assign xfer  = out_valid && out_ready;

  always_comb begin
    state_d   = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (finish_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (finish_i && wcnt == 6'(N - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (rcnt == 5'(N - 1));
        if (xfer && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (finish_i) wcnt <= 6'd1;
        end
        CAPTURE: begin
          if (finish_i) wcnt <= wcnt + 6'd1;
          rcnt <= '0;
        end
        DRAIN: begin
          // Strobes in DRAIN are dropped. This includes a strobe on the final
          // transfer cycle; it does not start the next frame.
          if (finish_i) overflow <= 1'b1;
          if (xfer)     rcnt     <= rcnt + 5'd1;
          if (state_d == IDLE) wcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; a frame is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) buffer[waddr] <= '{re: X_r, im: X_i};
  end

  assign out_r   = buffer[rcnt].re;
  assign out_i   = buffer[rcnt].im;
  assign out_idx = rcnt;

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed bench for fft_out_collector. Test cases: reset state, basic
// order, capture gaps, backpressure, overflow, mid-frame and mid-drain
// reset, and a strobe during the final transfer.
module tb_fft_out_collector;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          finish_i;
  logic [DW-1:0] X_r, X_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r, out_i;
  logic [4:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  fft_out_collector #(.DW(DW), .N(32)) dut (
    .clk(clk), .rst(rst), .finish_i(finish_i), .X_r(X_r), .X_i(X_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] br5(input logic [4:0] k);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[b] = k[4-b];
    return r;
  endfunction

  // Slot j holds the sample whose arrival number maps to address j.
  function automatic logic [DW-1:0] exp_r(input int base, input int j);
`ifdef FFT_OUT_BITREV_EN
    return DW'(base + int'(br5(5'(j))));
`else
    return DW'(base + j);
`endif
  endfunction

  function automatic logic [DW-1:0] exp_i(input int base, input int j);
    logic [DW-1:0] v;
    v = exp_r(base, j);
    return -v;
  endfunction

  // Sends n samples X_r=base+k, X_i=-(base+k), with 'gaps' idle cycles
  // between samples. Ends on the negedge after the last capture.
  task automatic send_frame(input int base, input int gaps, input int n);
    logic [DW-1:0] v;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v        = DW'(base + k);
      finish_i = 1'b1;
      X_r      = v;
      X_i      = -v;
      if (k == n - 1 && k > 0) begin
        chk("cap_busy", 32'(busy), 32'd1);
        chk("cap_novld", 32'(out_valid), 32'd0);
      end
      if (k < n - 1) begin
        repeat (gaps) begin
          @(negedge clk);
          finish_i = 1'b0;
          X_r      = '1;
          X_i      = '1;
        end
      end
    end
    @(negedge clk);
    finish_i = 1'b0;
    if (n == 32) chk("lat_vld", 32'(out_valid), 32'd1);
  endtask

  // Drains stop_at results starting at a negedge. 'stall' toggles out_ready
  // 1,0,1,0. 'ovf' strobes finish_i in the first cycles. 'fin_last' strobes
  // finish_i on the final transfer.
  task automatic drain(input int base, input bit stall, input int ovf,
                       input bit fin_last, input int stop_at);
    int            cnt = 0;
    int            cyc = 0;
    bit            rdy;
    bit            stalled = 1'b0;
    logic [DW-1:0] pr = '0;
    while (cnt < stop_at && cyc < 400) begin
      rdy       = stall ? (cyc % 2 == 0) : 1'b1;
      out_ready = rdy;
      finish_i  = (cyc < ovf) || (fin_last && cnt == 31 && rdy);
      X_r       = 18'h2AAAA;
      X_i       = 18'h15555;
      #1;
      chk("vld", 32'(out_valid), 32'd1);
      chk("idx", 32'(out_idx), 32'(cnt));
      chk("out_r", 32'(out_r), 32'(exp_r(base, cnt)));
      chk("out_i", 32'(out_i), 32'(exp_i(base, cnt)));
      chk("last", 32'(out_last), 32'(cnt == 31));
      if (stalled) chk("hold_r", 32'(out_r), 32'(pr));
      pr      = out_r;
      stalled = !rdy;
      @(posedge clk);
      if (rdy) cnt++;
      cyc++;
      @(negedge clk);
    end
    finish_i  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 400) chk("drain_timeout", 32'(cnt), 32'(stop_at));
    if (stop_at == 32) begin
      #1;
      chk("end_vld", 32'(out_valid), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; finish_i = 1'b0; out_ready = 1'b0; X_r = '0; X_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // basic order
    send_frame(0, 0, 32);
    drain(0, 1'b0, 0, 1'b0, 32);

    // capture gaps 1,0,0,1,...
    send_frame(0, 2, 32);
    drain(0, 1'b0, 0, 1'b0, 32);

    // backpressure
    send_frame(200, 0, 32);
    drain(200, 1'b1, 0, 1'b0, 32);

    // overflow during drain, sticky across frames
    chk("ovf_pre", 32'(overflow), 32'd0);
    send_frame(300, 0, 32);
    drain(300, 1'b0, 3, 1'b0, 32);
    chk("ovf_set", 32'(overflow), 32'd1);
    send_frame(0, 0, 32);
    drain(0, 1'b0, 0, 1'b0, 32);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // mid-frame reset
    send_frame(50, 0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mfr_busy", 32'(busy), 32'd0);
    chk("mfr_ovf", 32'(overflow), 32'd0);
    send_frame(100, 0, 32);
    drain(100, 1'b0, 0, 1'b0, 32);
    chk("mfr_ovf2", 32'(overflow), 32'd0);

    // mid-drain reset at rcnt=5
    send_frame(400, 0, 32);
    drain(400, 1'b0, 0, 1'b0, 5);
    chk("mdr_idx", 32'(out_idx), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mdr_vld", 32'(out_valid), 32'd0);
    chk("mdr_busy", 32'(busy), 32'd0);
    send_frame(500, 0, 32);
    drain(500, 1'b0, 0, 1'b0, 32);

    // strobe on the final transfer is dropped, not a new frame
    chk("b2b_ovf_pre", 32'(overflow), 32'd0);
    send_frame(600, 0, 32);
    drain(600, 1'b0, 0, 1'b1, 32);
    chk("b2b_ovf", 32'(overflow), 32'd1);
    send_frame(700, 0, 32);
    drain(700, 1'b0, 0, 1'b0, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_out_collector.md
FFT_OUT_COLLECTOR -- requirements
Module: fft_out_collector

Interface
REQ-001 SHALL have parameter DW, default 18, the width of each real and imaginary result word.
REQ-002 SHALL have parameter N, default 32, the number of points per frame; it is fixed at 32 and the index width is 5.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port finish_i, input, 1 bit: the FFT result-valid strobe; X_r and X_i are valid in any cycle where it is high.
REQ-006 SHALL have port X_r, input, DW bits: real part of the FFT result, two's complement.
REQ-007 SHALL have port X_i, input, DW bits: imaginary part of the FFT result, two's complement.
REQ-008 SHALL have port out_valid, output, 1 bit: a buffered result is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream side accepts the presented result.
REQ-010 SHALL have port out_r, output, DW bits: the presented real part.
REQ-011 SHALL have port out_i, output, DW bits: the presented imaginary part.
REQ-012 SHALL have port out_idx, output, 5 bits: sequence number of the presented result, 0 to 31.
REQ-013 SHALL have port out_last, output, 1 bit: high with out_valid when out_idx equals 31.
REQ-014 SHALL have port busy, output, 1 bit: high while the state is CAPTURE or DRAIN.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set when a result is dropped.

Function
REQ-016 SHALL implement three states: IDLE, CAPTURE and DRAIN, with a 32-entry by 2*DW register buffer, a 6-bit write count wcnt and a 5-bit read count rcnt.
REQ-017 In IDLE, a cycle with finish_i high SHALL write {X_r,X_i} to buffer address A(0), set wcnt=1 and move to CAPTURE.
REQ-018 In CAPTURE, each cycle with finish_i high SHALL write to A(wcnt) and increment wcnt; cycles with finish_i low are gaps that write nothing and change no state.
REQ-019 When the 32nd write completes (wcnt reaches 32), the next state SHALL be DRAIN with rcnt=0; out_valid SHALL assert in the cycle after the 32nd capture edge.
REQ-020 In DRAIN, out_valid SHALL be 1 and out_r/out_i SHALL equal buffer[rcnt]; out_idx SHALL equal rcnt.
REQ-021 A transfer occurs on a rising edge where out_valid and out_ready are both high; each transfer SHALL increment rcnt.
REQ-022 While out_valid is high and out_ready is low, out_r, out_i, out_idx and out_last SHALL hold stable.
REQ-023 The transfer with out_last high SHALL return the state to IDLE; out_valid SHALL be 0 in the following cycle.
REQ-024 A cycle with finish_i high during DRAIN SHALL drop that sample, leave the buffer unchanged and set overflow to 1; overflow is cleared only by rst.
REQ-025 In IDLE and CAPTURE, out_valid and out_last SHALL be 0; out_r, out_i and out_idx are don't-care there.
REQ-026 Data SHALL pass through bit-exact; the block performs no arithmetic, scaling or saturation.
REQ-027 Back-to-back frames: a finish_i high in the cycle of the final DRAIN transfer SHALL be counted as an overflow drop, not as the start of the next frame.

Reset
REQ-028 When rst is sampled high: state=IDLE, wcnt=0, rcnt=0, out_valid=0, out_last=0, busy=0, overflow=0 in the next cycle.
REQ-029 A reset in the middle of CAPTURE or DRAIN SHALL abandon the frame; the next finish_i high starts a new frame at address A(0).
REQ-030 The buffer contents need not be reset.

Configuration
REQ-031 Macro FFT_OUT_BITREV_EN SHALL select the buffer addressing.
REQ-032 When FFT_OUT_BITREV_EN is defined, A(k) SHALL be the 5-bit bit-reversal of k, so results are emitted in natural frequency order; for example, the 2nd arrival (k=1) is stored at address 16.
REQ-033 When FFT_OUT_BITREV_EN is undefined, A(k)=k, so results are emitted in arrival order.

Verification
REQ-034 Basic order test: 32 consecutive finish_i cycles with X_r=k, X_i=-k for k=0..31, out_ready tied to 1 -> out_valid asserts in the cycle after capture 31. Without the macro: 32 transfers with out_r=0..31. With the macro: out_r=bitrev(0..31). out_last is high only on transfer 31; busy then falls.
REQ-035 Capture gaps: finish_i pattern 1,0,0,1,... delivering 32 samples -> data and order are identical to the basic order test; there is no extra latency beyond the last capture.
REQ-036 Backpressure: out_ready toggled 1,0,1,0 -> 32 transfers; the outputs hold stable during every stall cycle.
REQ-037 Overflow: finish_i=1 for 3 cycles during DRAIN -> overflow=1, the drained data equals the original frame, and overflow remains 1 after return to IDLE.
REQ-038 Mid-frame reset: rst=1 for 1 cycle after 10 captures, then a full 32-sample frame with X_r=100+k -> the output is 100..131 (in the ordering set by the macro), overflow=0.
REQ-039 Mid-drain reset: rst asserted at rcnt=5 -> out_valid=0 in the next cycle, busy=0, and the following frame drains normally.
